// File: rtl/target_reach_monitor_if.sv
// target_reach_monitor_if: head/target inputs and pulse/score outputs of the reach monitor
interface target_reach_monitor_if;
  logic [1:0] master_state;
  logic [7:0] head_addrh;
  logic [6:0] head_addrv;
  logic       head_valid;
  logic [7:0] target_addrh;
  logic [6:0] target_addrv;
  logic       trig;
  logic       reached;
  logic [7:0] score;
  logic       win;
  modport master (output master_state, head_addrh, head_addrv, head_valid, target_addrh, target_addrv,
                  input trig, reached, score, win);
  modport slave  (input master_state, head_addrh, head_addrv, head_valid, target_addrh, target_addrv,
                  output trig, reached, score, win);
endinterface

// File: rtl/target_reach_monitor.sv
// target_reach_monitor: detects the snake head landing on the target and keeps a BCD score
module target_reach_monitor #(
  parameter int WIN_SCORE     = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  target_reach_monitor_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, SETTLE, PLAY, DONE} state_t;
  localparam logic [7:0] WIN_BCD   = 8'(((WIN_SCORE / 10) << 4) | (WIN_SCORE % 10));
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] score, score_n, score_inc;
  logic       win, win_n, trig, trig_n, reached, reached_n, hit;
  assign hit = bus.head_valid && bus.head_addrh == bus.target_addrh && bus.head_addrv == bus.target_addrv;
  assign score_inc = score == 8'h99 ? score :
                     score[3:0] == 4'd9 ? {score[7:4] + 4'd1, 4'd0} : score + 8'd1;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    score_n   = score;
    win_n     = win;
    trig_n    = 1'b0;
    reached_n = 1'b0;
    if (bus.master_state == 2'b00) begin
      state_n = IDLE;
      cnt_n   = 4'd0;
      score_n = 8'h00;
      win_n   = 1'b0;
    end else if (bus.master_state == 2'b01) begin
      case (state)
        IDLE: begin
          state_n = ARM;
          trig_n  = 1'b1;
        end
        ARM: begin
          state_n = SETTLE;
          cnt_n   = SETTLE_LD;
        end
        SETTLE: begin
          state_n = cnt <= 4'd1 ? PLAY : SETTLE;
          cnt_n   = cnt <= 4'd1 ? 4'd0 : cnt - 4'd1;
        end
        PLAY: if (hit) begin
          reached_n = 1'b1;
          score_n   = score_inc;
          win_n     = score_inc == WIN_BCD;
          state_n   = score_inc == WIN_BCD ? DONE : SETTLE;
          cnt_n     = score_inc == WIN_BCD ? cnt : SETTLE_LD;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      score   <= 8'h00;
      win     <= 1'b0;
      trig    <= 1'b0;
      reached <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      score   <= score_n;
      win     <= win_n;
      trig    <= trig_n;
      reached <= reached_n;
    end
  end
  assign bus.trig    = trig;
  assign bus.reached = reached;
  assign bus.score   = score;
  assign bus.win     = win;
endmodule

// File: tb/tb_target_reach_monitor.sv
// tb_target_reach_monitor: directed checks of start, hit/miss, BCD win, freeze and reset behaviour
module tb_target_reach_monitor;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  target_reach_monitor_if bus ();
  target_reach_monitor #(.WIN_SCORE(10), .SETTLE_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction
  task automatic do_hit(input int n);
    bus.head_valid = 1'b1;
    step();
    bus.head_valid = 1'b0;
    chk("hit_reached", {7'd0, bus.reached}, 8'd1);
    chk("hit_score", bus.score, bcd(n));
    step();
    step();
  endtask
  initial begin
    reset = 1'b1;
    bus.master_state = 2'b00;
    bus.head_valid   = 1'b0;
    bus.head_addrh   = 8'd40;
    bus.head_addrv   = 7'd30;
    bus.target_addrh = 8'd40;
    bus.target_addrv = 7'd30;
    step();
    step();
    chk("rst_score", bus.score, 8'h00);
    chk("rst_win", {7'd0, bus.win}, 8'd0);
    chk("rst_trig", {7'd0, bus.trig}, 8'd0);
    chk("rst_reached", {7'd0, bus.reached}, 8'd0);
    reset = 1'b0;
    step();
    chk("idle_trig", {7'd0, bus.trig}, 8'd0);
    bus.master_state = 2'b01;
    step();
    chk("arm_trig", {7'd0, bus.trig}, 8'd1);
    chk("arm_reached", {7'd0, bus.reached}, 8'd0);
    bus.head_valid = 1'b1;
    step();
    chk("settle1_trig", {7'd0, bus.trig}, 8'd0);
    chk("settle1_reached", {7'd0, bus.reached}, 8'd0);
    step();
    chk("settle2_reached", {7'd0, bus.reached}, 8'd0);
    step();
    chk("play_entry_reached", {7'd0, bus.reached}, 8'd0);
    chk("play_entry_score", bus.score, 8'h00);
    step();
    chk("hit1_reached", {7'd0, bus.reached}, 8'd1);
    chk("hit1_score", bus.score, 8'h01);
    step();
    chk("post_hit_a_reached", {7'd0, bus.reached}, 8'd0);
    step();
    chk("post_hit_b_reached", {7'd0, bus.reached}, 8'd0);
    chk("post_hit_score", bus.score, 8'h01);
    bus.head_addrv = 7'd31;
    step();
    chk("miss_reached", {7'd0, bus.reached}, 8'd0);
    chk("miss_score", bus.score, 8'h01);
    bus.head_addrv = 7'd30;
    bus.head_valid = 1'b0;
    step();
    chk("novalid_reached", {7'd0, bus.reached}, 8'd0);
    for (int i = 2; i <= 4; i++) do_hit(i);
    bus.head_valid = 1'b1;
    step();
    bus.head_valid = 1'b0;
    chk("hit5_reached", {7'd0, bus.reached}, 8'd1);
    chk("hit5_score", bus.score, 8'h05);
    step();
    bus.master_state = 2'b10;
    bus.head_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frz_reached", {7'd0, bus.reached}, 8'd0);
      chk("frz_trig", {7'd0, bus.trig}, 8'd0);
    end
    chk("frz_score", bus.score, 8'h05);
    bus.master_state = 2'b01;
    step();
    chk("resume_settle_reached", {7'd0, bus.reached}, 8'd0);
    step();
    chk("resume_hit_reached", {7'd0, bus.reached}, 8'd1);
    chk("resume_hit_score", bus.score, 8'h06);
    bus.head_valid = 1'b0;
    step();
    step();
    for (int i = 7; i <= 9; i++) do_hit(i);
    chk("nine_score", bus.score, 8'h09);
    chk("nine_win", {7'd0, bus.win}, 8'd0);
    bus.head_valid = 1'b1;
    step();
    chk("ten_reached", {7'd0, bus.reached}, 8'd1);
    chk("ten_score", bus.score, 8'h10);
    chk("ten_win", {7'd0, bus.win}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("done_reached", {7'd0, bus.reached}, 8'd0);
      chk("done_trig", {7'd0, bus.trig}, 8'd0);
    end
    chk("done_score", bus.score, 8'h10);
    chk("done_win", {7'd0, bus.win}, 8'd1);
    bus.master_state = 2'b00;
    bus.head_valid = 1'b0;
    step();
    chk("idle_clear_score", bus.score, 8'h00);
    chk("idle_clear_win", {7'd0, bus.win}, 8'd0);
    bus.master_state = 2'b01;
    step();
    chk("g2_trig", {7'd0, bus.trig}, 8'd1);
    step();
    step();
    step();
    bus.head_valid = 1'b1;
    bus.master_state = 2'b00;
    step();
    chk("prio_reached", {7'd0, bus.reached}, 8'd0);
    chk("prio_score", bus.score, 8'h00);
    bus.head_valid = 1'b0;
    bus.master_state = 2'b01;
    step();
    chk("g3_trig", {7'd0, bus.trig}, 8'd1);
    step();
    step();
    step();
    for (int i = 1; i <= 5; i++) do_hit(i);
    chk("pre_rst_score", bus.score, 8'h05);
    reset = 1'b1;
    bus.head_valid = 1'b1;
    step();
    chk("rst_mid_score", bus.score, 8'h00);
    chk("rst_mid_trig", {7'd0, bus.trig}, 8'd0);
    chk("rst_mid_reached", {7'd0, bus.reached}, 8'd0);
    chk("rst_mid_win", {7'd0, bus.win}, 8'd0);
    reset = 1'b0;
    bus.head_valid = 1'b0;
    step();
    chk("rst_rearm_trig", {7'd0, bus.trig}, 8'd1);
    chk("rst_rearm_reached", {7'd0, bus.reached}, 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
